key_cmd_arbiter: RTL and testbench
==================================

Name: key_cmd_arbiter

Overview:
- Collects one-cycle press pulses from up to NKEYS debounced keys on the OV7670 control panel.
- Holds one pending request per key and grants the keys round-robin to the single shared SCCB/I2C register-write engine.
- Issues one command at a time with a valid/ready handshake, waits for completion or timeout, then enforces a bus-idle gap before the next grant.

Parameters:
- NKEYS, 4, number of key requesters (2..16).
- KW, 2, width of cmd_key; NKEYS <= 2^KW.
- TW, 16, width of the timeout and gap timer.
- TIMEOUT, 50000, cycles allowed in WAIT_DONE before abort (2..2^TW-1).
- GAP_CYCLES, 1000, bus-idle cycles after each command (1..2^TW-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- key_tick  in  NKEYS  one-cycle press pulse per key, from the debouncers.
- cmd_valid  out  1  command offered to the I2C engine.
- cmd_key  out  KW  index of the granted key; stable while cmd_valid=1.
- cmd_ready  in  1  engine accepts the command when cmd_valid=1 and cmd_ready=1.
- cmd_done  in  1  one-cycle pulse when the engine finishes the accepted command.
- busy  out  1  high whenever state is not IDLE.
- pending  out  NKEYS  current pending request flags.
- timeout_err  out  1  one-cycle pulse when WAIT_DONE times out.
- drop_cnt  out  8  saturating count of coalesced presses.

Behaviour:
- Reset:
  - Reset rst_n, asynchronous, active-low; clock clk.
  - Reset clears all state and outputs: state=IDLE, pending=0, cmd_valid=0, cmd_key=0, timeout_err=0, drop_cnt=0, timer=0, last_grant=NKEYS-1.
  - Asserting reset mid-command drops cmd_valid immediately and discards all pending requests.
- Pending flags:
  - key_tick[k]=1 sets pending[k] on the next edge.
  - If pending[k] is already 1 and is not being cleared this cycle, the tick is coalesced and drop_cnt increments, saturating at 255. Several coalesced ticks in one cycle add 1 only.
  - If a grant clears pending[k] on the same edge that key_tick[k]=1, the set wins: pending[k] stays 1 and the press is not lost or counted as dropped.
  - Ticks on different keys in the same cycle are all recorded.
- FSM (registered state):
  - IDLE:
    - If any pending bit is set, choose the first set bit scanning from last_grant+1 upward, mod NKEYS.
    - On that edge: cmd_key=winner, last_grant=winner, clear pending[winner], cmd_valid=1, go to ISSUE.
    - Latency: tick sampled at edge E gives cmd_valid high after edge E+1.
  - ISSUE:
    - Hold cmd_valid and cmd_key until cmd_ready=1 is sampled.
    - On that edge: cmd_valid=0, timer=0, go to WAIT_DONE.
    - No timeout applies in ISSUE.
  - WAIT_DONE:
    - timer increments every cycle.
    - cmd_done=1: timer=0, go to GAP.
    - Otherwise, when timer==TIMEOUT-1: timeout_err pulses for one cycle (registered), timer=0, go to GAP.
    - If cmd_done and the timeout coincide, done wins and there is no error.
  - GAP:
    - timer increments; when timer==GAP_CYCLES-1, go to IDLE.
    - Residency is exactly GAP_CYCLES cycles.
- cmd_done is ignored outside WAIT_DONE. The engine must not pulse done in the same cycle it accepts.
- busy is combinational from state (state != IDLE). pending and drop_cnt come directly from registers.
- Fairness: a continuously pending key waits at most NKEYS-1 other commands before it is served.
- The timer is TW bits and never wraps within a state, because parameters are bounded below 2^TW.

Test Plan:
- Reset then single tick: key_tick=4'b0100 for one cycle, cmd_ready=1 immediately, cmd_done 5 cycles later.
  - cmd_valid high after 2 edges with cmd_key=2.
  - Then a 5-cycle WAIT_DONE, a 1000-cycle GAP, busy low afterwards, drop_cnt=0.
- Simultaneous ticks key_tick=4'b1111 from reset:
  - Grant order is 0,1,2,3.
  - Then re-pend keys 0 and 3 while key 1's command is in progress; next grants are 3, then 0 (round-robin from last_grant).
- Coalescing: tick key 1 three times while it is pending and the FSM is busy on key 0.
  - pending[1] stays 1, drop_cnt=2, and exactly one cmd_key=1 is issued.
  - Force 300 coalesced ticks: drop_cnt saturates at 255.
- Set-wins: assert key_tick[2] on the exact edge key 2 is granted.
  - After the grant, pending[2]=1 and a second cmd_key=2 follows after the gap.
- Timeout: with TIMEOUT=8, accept the command but never pulse cmd_done.
  - timeout_err pulses exactly once, 8 cycles after WAIT_DONE entry, then GAP.
  - Repeat with cmd_done on the 8th cycle: no error.
- Backpressure and reset: hold cmd_ready=0 for 20 cycles.
  - cmd_valid and cmd_key stay stable throughout.
  - Assert rst_n=0 mid-ISSUE: cmd_valid, pending and busy go to 0 asynchronously, and resumption after reset starts from key 0.

Source files
------------

// File: rtl/key_cmd_arbiter.sv
// Round-robin arbiter that turns debounced key presses into one-at-a-time commands
// for the shared SCCB/I2C write engine, with timeout and a bus-idle gap after each command.
module key_cmd_arbiter #(
  parameter int NKEYS      = 4,
  parameter int KW         = 2,
  parameter int TW         = 16,
  parameter int TIMEOUT    = 50000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_tick,
  output logic             cmd_valid,
  output logic [KW-1:0]    cmd_key,
  input  logic             cmd_ready,
  input  logic             cmd_done,
  output logic             busy,
  output logic [NKEYS-1:0] pending,
  output logic             timeout_err,
  output logic [7:0]       drop_cnt
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NKEYS-1:0] pending_q, pending_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [KW-1:0]    cmd_key_q, cmd_key_d;
  logic [KW-1:0]    last_grant_q, last_grant_d;
  logic             timeout_err_q, timeout_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             grant_found;
  logic [KW-1:0]    grant_idx;
  logic [KW:0]      cand;
  logic             grant_now;
  logic [NKEYS-1:0] clear_vec;

  // Round-robin scan: first pending key after last_grant, wrapping modulo NKEYS.
  // NOTE: always_comb gives every output a default first so no path leaves a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NKEYS; i++) begin
      cand = {1'b0, last_grant_q} + (KW+1)'(i);
      if (cand >= (KW+1)'(NKEYS)) cand = cand - (KW+1)'(NKEYS);
      if (!grant_found && pending_q[cand[KW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[KW-1:0];
      end
    end
  end

  assign grant_now = (state_q == ST_IDLE) && grant_found;
  assign clear_vec = grant_now ? (NKEYS'(1) << grant_idx) : '0;

  // A tick arriving on the grant edge re-sets the flag, so that press is kept.
  always_comb begin
    pending_d  = (pending_q & ~clear_vec) | key_tick;
    drop_cnt_d = drop_cnt_q;
    if ((|(key_tick & pending_q & ~clear_vec)) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_key_d     = cmd_key_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          cmd_key_d    = grant_idx;
          last_grant_d = grant_idx;
          cmd_valid_d  = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (cmd_done) begin
          timer_d = '0;
          state_d = ST_GAP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          timer_d       = '0;
          state_d       = ST_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_key_q     <= '0;
      last_grant_q  <= KW'(NKEYS - 1);
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_key_q     <= cmd_key_d;
      last_grant_q  <= last_grant_d;
      timeout_err_q <= timeout_err_d;
      drop_cnt_q    <= drop_cnt_d;
      timer_q       <= timer_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign cmd_valid   = cmd_valid_q;
  assign cmd_key     = cmd_key_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Directed self-checking bench for key_cmd_arbiter (TIMEOUT=8, GAP_CYCLES=1000).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_key_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_tick;
  logic       cmd_valid;
  logic [1:0] cmd_key;
  logic       cmd_ready;
  logic       cmd_done;
  logic       busy;
  logic [3:0] pending;
  logic       timeout_err;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  key_cmd_arbiter #(
    .NKEYS(4), .KW(2), .TW(16), .TIMEOUT(8), .GAP_CYCLES(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_tick(key_tick),
    .cmd_valid(cmd_valid), .cmd_key(cmd_key), .cmd_ready(cmd_ready),
    .cmd_done(cmd_done), .busy(busy), .pending(pending),
    .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done;
    cmd_done = 1'b1;
    step(1);
    cmd_done = 1'b0;
  endtask

  // Accept on the next edge (cmd_ready=1), then finish 3 cycles into WAIT_DONE.
  task automatic serve;
    step(3);
    pulse_done();
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok, output logic [1:0] key);
    ok  = 1'b0;
    key = 2'bxx;
    for (int i = 0; i < max_cyc; i++) begin
      if (cmd_valid === 1'b1) begin
        ok  = 1'b1;
        key = cmd_key;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_tick = '0; cmd_ready = 1'b1; cmd_done = 1'b0;
    step(3);
    n_checks++;
    if ({cmd_valid, cmd_key, busy, pending, timeout_err, drop_cnt} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b key=%0d busy=%b pend=%b terr=%b drop=%0d, want all 0",
               cmd_valid, cmd_key, busy, pending, timeout_err, drop_cnt);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single;
    key_tick = 4'b0100;
    step(1);
    key_tick = '0;
    n_checks++;
    if (pending !== 4'b0100 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1: got pend=%b valid=%b, want 0100/0", pending, cmd_valid);
    end
    step(1);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_key !== 2'd2 || pending !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got valid=%b key=%0d pend=%b busy=%b, want 1/2/0000/1",
               cmd_valid, cmd_key, pending, busy);
    end
    step(1);
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got valid=%b busy=%b, want 0/1", cmd_valid, busy);
    end
    step(4);
    pulse_done();
    n_checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got terr=%b busy=%b, want 0/1", timeout_err, busy);
    end
    step(999);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap_end: got busy=%b at gap cycle 999, want 1", busy);
    end
    step(1);
    n_checks++;
    if (busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b drop=%0d, want 0/0", busy, drop_cnt);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    logic [1:0] k;
    logic [1:0] exp_order [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    key_tick = 4'b1111;
    step(1);
    key_tick = '0;
    n_checks++;
    if (pending !== 4'b1111) begin
      n_fail++;
      $display("FAIL rr_pending_all: got %b, want 1111", pending);
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid(1100, ok, k);
      n_checks++;
      if (!ok || k !== exp_order[i]) begin
        n_fail++;
        $display("FAIL rr_order_%0d: got ok=%b key=%0d, want key %0d", i, ok, k, exp_order[i]);
      end
      serve();
    end
    wait_idle(1100, ok);
    key_tick = 4'b0010;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    n_checks++;
    if (!ok || k !== 2'd1) begin
      n_fail++;
      $display("FAIL rr_key1: got ok=%b key=%0d, want key 1", ok, k);
    end
    key_tick = 4'b1001;
    step(1);
    key_tick = '0;
    n_checks++;
    if (pending !== 4'b1001) begin
      n_fail++;
      $display("FAIL rr_repend: got %b, want 1001", pending);
    end
    step(1);
    pulse_done();
    wait_valid(1100, ok, k);
    n_checks++;
    if (!ok || k !== 2'd3) begin
      n_fail++;
      $display("FAIL rr_after1_first: got ok=%b key=%0d, want key 3", ok, k);
    end
    serve();
    wait_valid(1100, ok, k);
    n_checks++;
    if (!ok || k !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_after1_second: got ok=%b key=%0d, want key 0", ok, k);
    end
    serve();
    wait_idle(1100, ok);
    n_checks++;
    if (!ok || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rr_idle: got idle=%b drop=%0d, want 1/0", ok, drop_cnt);
    end
  endtask

  task automatic test_coalesce;
    bit ok;
    logic [1:0] k;
    key_tick = 4'b0001;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    n_checks++;
    if (!ok || k !== 2'd0) begin
      n_fail++;
      $display("FAIL coal_key0: got ok=%b key=%0d, want key 0", ok, k);
    end
    key_tick = 4'b0010;
    step(3);
    key_tick = '0;
    n_checks++;
    if (pending !== 4'b0010 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL coal_count: got pend=%b drop=%0d, want 0010/2", pending, drop_cnt);
    end
    pulse_done();
    wait_valid(1100, ok, k);
    n_checks++;
    if (!ok || k !== 2'd1) begin
      n_fail++;
      $display("FAIL coal_key1: got ok=%b key=%0d, want key 1", ok, k);
    end
    serve();
    wait_idle(1100, ok);
    step(5);
    n_checks++;
    if (!ok || cmd_valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL coal_single_issue: got idle=%b valid=%b pend=%b, want 1/0/0000",
               ok, cmd_valid, pending);
    end
  endtask

  task automatic test_set_wins;
    bit ok;
    logic [1:0] k;
    key_tick = 4'b0100;
    step(2);
    key_tick = '0;
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_key !== 2'd2 || pending !== 4'b0100 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL setwins_grant: got valid=%b key=%0d pend=%b drop=%0d, want 1/2/0100/2",
               cmd_valid, cmd_key, pending, drop_cnt);
    end
    serve();
    wait_valid(1100, ok, k);
    n_checks++;
    if (!ok || k !== 2'd2) begin
      n_fail++;
      $display("FAIL setwins_second: got ok=%b key=%0d, want key 2", ok, k);
    end
    serve();
    wait_idle(1100, ok);
  endtask

  task automatic test_saturate;
    bit ok;
    logic [1:0] k;
    cmd_ready = 1'b0;
    key_tick = 4'b0001;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    key_tick = 4'b0010;
    step(301);
    key_tick = '0;
    n_checks++;
    if (drop_cnt !== 8'd255 || pending !== 4'b0010 || cmd_valid !== 1'b1 || cmd_key !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_drop: got drop=%0d pend=%b valid=%b key=%0d, want 255/0010/1/0",
               drop_cnt, pending, cmd_valid, cmd_key);
    end
    cmd_ready = 1'b1;
    serve();
    wait_valid(1100, ok, k);
    n_checks++;
    if (!ok || k !== 2'd1) begin
      n_fail++;
      $display("FAIL sat_next: got ok=%b key=%0d, want key 1", ok, k);
    end
    serve();
    wait_idle(1100, ok);
  endtask

  task automatic test_timeout;
    bit ok;
    logic [1:0] k;
    key_tick = 4'b1000;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    step(1);
    step(7);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_early: got terr=%b after 7 wait cycles, want 0", timeout_err);
    end
    step(1);
    n_checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_pulse: got terr=%b busy=%b after 8 wait cycles, want 1/1", timeout_err, busy);
    end
    step(1);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_width: got terr=%b one cycle later, want 0", timeout_err);
    end
    wait_idle(1100, ok);
    key_tick = 4'b0001;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    step(1);
    step(7);
    pulse_done();
    n_checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_done_wins: got terr=%b busy=%b, want 0/1", timeout_err, busy);
    end
    step(1);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_wins_late: got terr=%b, want 0", timeout_err);
    end
    wait_idle(1100, ok);
  endtask

  task automatic test_backpressure_reset;
    bit ok;
    logic [1:0] k;
    cmd_ready = 1'b0;
    key_tick = 4'b0010;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    for (int i = 0; i < 20; i++) begin
      key_tick = (i == 5) ? 4'b0101 : 4'b0000;
      step(1);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_key !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_stable_%0d: got valid=%b key=%0d, want 1/1", i, cmd_valid, cmd_key);
      end
    end
    key_tick = '0;
    n_checks++;
    if (pending !== 4'b0101) begin
      n_fail++;
      $display("FAIL bp_pending: got %b, want 0101", pending);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b pend=%b busy=%b drop=%0d, want 0/0000/0/0",
               cmd_valid, pending, busy, drop_cnt);
    end
    step(2);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    step(3);
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got valid=%b busy=%b, want 0/0", cmd_valid, busy);
    end
    key_tick = 4'b0101;
    step(1);
    key_tick = '0;
    wait_valid(5, ok, k);
    n_checks++;
    if (!ok || k !== 2'd0) begin
      n_fail++;
      $display("FAIL resume_first: got ok=%b key=%0d, want key 0", ok, k);
    end
    serve();
    wait_valid(1100, ok, k);
    n_checks++;
    if (!ok || k !== 2'd2) begin
      n_fail++;
      $display("FAIL resume_second: got ok=%b key=%0d, want key 2", ok, k);
    end
    serve();
    wait_idle(1100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL resume_idle: got busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_coalesce();
    test_set_wins();
    test_saturate();
    test_timeout();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
